// File: rtl/muldiv_unit_pkg.sv
// Shared opcodes, FSM states and step modes for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam int MD_OP_LENGTH = 3;

    typedef enum logic [MD_OP_LENGTH-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned core: radix-2 shift-add multiply or restoring divide
// on a shared 2*WIDTH accumulator ({high half, low half}).
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  step_mode_e             mode_i,
    input  logic [2*WIDTH-1:0]     acc_i,
    input  logic [WIDTH-1:0]       opnd_i,
    output logic [2*WIDTH-1:0]     acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH:0] shl;

    always_comb begin
        sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        shl  = {acc_i, 1'b0};
        diff = shl[2*WIDTH:WIDTH] - {1'b0, opnd_i};
        // Multiply consumes the multiplier from the low end; divide shifts the dividend
        // into the remainder and leaves quotient bits behind in the low half.
        if (mode_i == STEP_MUL) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_o = {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
        end else begin
            acc_o = shl[2*WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers, stall request
// and flush cancellation. Works on magnitudes and fixes signs in a final FIX cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MD_OP_LENGTH-1:0] op,
    input  logic [WIDTH-1:0]        src_a,
    input  logic [WIDTH-1:0]        src_b,
    input  logic                    flush,
    input  logic                    mf_req,
    input  logic                    mf_sel,
    output logic [WIDTH-1:0]        mf_data,
    output logic                    busy,
    output logic                    stall_req,
    output logic                    done,
    output logic                    div_by_zero,
    output logic [WIDTH-1:0]        hi,
    output logic [WIDTH-1:0]        lo
);

    md_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 is_div_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;
    logic                 dbz_q;
    logic                 done_q;
    logic                 dbz_out_q;

    md_op_e               op_e;
    logic                 accept;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;

    assign op_e   = md_op_e'(op);
    assign busy   = (state_q != MD_IDLE);
    assign accept = start & ~busy & ~flush;
    assign sign_a = op_is_signed(op_e) & src_a[WIDTH-1];
    assign sign_b = op_is_signed(op_e) & src_b[WIDTH-1];
    assign mag_a  = sign_a ? -src_a : src_a;
    assign mag_b  = sign_b ? -src_b : src_b;

    assign prod = neg_res_q ? -acc_q : acc_q;
    assign quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_i (is_div_q ? STEP_DIV : STEP_MUL),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_d)
    );

    // NOTE: every register, HI/LO included, is cleared by the async reset; state uses <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        case (op_e)
                            MD_MULT, MD_MULTU: begin
                                state_q   <= MD_RUN;
                                cnt_q     <= '0;
                                acc_q     <= {{WIDTH{1'b0}}, mag_b};
                                opnd_q    <= mag_a;
                                is_div_q  <= 1'b0;
                                neg_res_q <= sign_a ^ sign_b;
                                neg_rem_q <= 1'b0;
                                dbz_q     <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                state_q   <= MD_RUN;
                                cnt_q     <= '0;
                                acc_q     <= {{WIDTH{1'b0}}, mag_a};
                                opnd_q    <= mag_b;
                                a_q       <= src_a;
                                is_div_q  <= 1'b1;
                                neg_res_q <= sign_a ^ sign_b;
                                neg_rem_q <= sign_a;
                                dbz_q     <= (src_b == '0);
                            end
                            MD_MTHI: hi_q <= src_a;
                            MD_MTLO: lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                MD_RUN: begin
                    if (flush) begin
                        state_q <= MD_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH-1)) state_q <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    state_q <= MD_IDLE;
                    if (!flush) begin
                        done_q <= 1'b1;
                        if (!is_div_q) begin
                            {hi_q, lo_q} <= prod;
                        end else if (dbz_q) begin
                            hi_q      <= a_q;
                            lo_q      <= '1;
                            dbz_out_q <= 1'b1;
                        end else begin
                            hi_q <= rem;
                            lo_q <= quo;
                        end
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign stall_req   = busy & (start | mf_req);
    assign mf_data     = mf_sel ? hi_q : lo_q;
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
